// File: rtl/cache_nway_wb.sv
// cache_nway_wb: N-way set-associative write-back cache with tree pseudo-LRU and built-in writeback/allocate FSM.
// Build option: define CACHE_STATS_EN to enable the saturating hit/miss counters; otherwise both read 16'h0000.
module cache_nway_wb #(
    parameter int WAYS = 2,
    parameter int SETS = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [15:0]  mem_address,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [1:0]   mem_byte_enable,
    input  logic [15:0]  mem_wdata,
    output logic [15:0]  mem_rdata,
    output logic         mem_resp,
    output logic [15:0]  pmem_address,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [127:0] pmem_wdata,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp,
    output logic [15:0]  hit_count,
    output logic [15:0]  miss_count
);
    localparam int IW = $clog2(SETS);
    localparam int TW = 12 - IW;
    localparam int WW = $clog2(WAYS);
    localparam logic [1:0] CHECK = 2'd0, WRITEBACK = 2'd1, ALLOCATE = 2'd2;

    logic [1:0]      state;
    logic [WAYS-1:0] valid [SETS];
    logic [WAYS-1:0] dirty [SETS];
    logic [WAYS-1:1] plru  [SETS];
    logic [TW-1:0]   tags  [SETS][WAYS];
    logic [127:0]    lines [SETS][WAYS];
    logic [IW-1:0]   idx;
    logic [TW-1:0]   tag;
    logic [2:0]      word;
    logic            req, hit, do_write;
    logic [WW-1:0]   hit_way, victim, victim_q;
    logic [WAYS-1:1] plru_nx;
    logic [127:0]    hit_line, merged;

    assign idx          = mem_address[3+IW:4];
    assign tag          = mem_address[15:4+IW];
    assign word         = mem_address[3:1];
    assign req          = mem_read | mem_write;
    assign hit_line     = lines[idx][hit_way];
    assign mem_resp     = (state == CHECK) && req && hit;
    assign mem_rdata    = mem_resp ? hit_line[{word, 4'h0} +: 16] : 16'h0;
    assign do_write     = mem_resp && mem_write;
    assign pmem_read    = state == ALLOCATE;
    assign pmem_write   = state == WRITEBACK;
    assign pmem_address = pmem_write ? {tags[idx][victim_q], idx, 4'h0} : pmem_read ? {tag, idx, 4'h0} : 16'h0;
    assign pmem_wdata   = pmem_write ? lines[idx][victim_q] : 128'h0;

    // tag compare across all ways of the indexed set
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int i = 0; i < WAYS; i++)
            if (valid[idx][i] && tags[idx][i] == tag) begin
                hit     = 1'b1;
                hit_way = WW'(i);
            end
    end

    // victim: walk the PLRU tree (heap order, node 1 is root), overridden by the lowest invalid way
    always_comb begin
        int k;
        k = 1;
        for (int l = 0; l < WW; l++) k = 2 * k + int'(plru[idx][k]);
        victim = WW'(k - WAYS);
        for (int i = WAYS - 1; i >= 0; i--)
            if (!valid[idx][i]) victim = WW'(i);
    end

    // point every node on the hit way's path at the opposite subtree
    always_comb begin
        int k;
        plru_nx = plru[idx];
        k = 1;
        for (int l = 0; l < WW; l++) begin
            plru_nx[k] = ~hit_way[WW-1-l];
            k = 2 * k + int'(hit_way[WW-1-l]);
        end
    end

    // byte-masked merge of the CPU write word into the hit line
    always_comb begin
        merged = hit_line;
        if (mem_byte_enable[0]) merged[{word, 4'h0} +: 8] = mem_wdata[7:0];
        if (mem_byte_enable[1]) merged[{word, 4'h8} +: 8] = mem_wdata[15:8];
    end

    // tag and data arrays: write hits and line fills, deliberately not reset
    always_ff @(posedge clk)
        if (do_write)
            lines[idx][hit_way] <= merged;
        else if (pmem_read && pmem_resp) begin
            lines[idx][victim_q] <= pmem_rdata;
            tags[idx][victim_q]  <= tag;
        end

    // control FSM with valid/dirty/PLRU state
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state    <= CHECK;
            victim_q <= '0;
            for (int i = 0; i < SETS; i++) begin
                valid[i] <= '0;
                dirty[i] <= '0;
                plru[i]  <= '0;
            end
        end else
            case (state)
                CHECK:
                    if (req && hit) begin
                        plru[idx] <= plru_nx;
                        if (mem_write && |mem_byte_enable) dirty[idx][hit_way] <= 1'b1;
                    end else if (req) begin
                        victim_q <= victim;
                        state    <= (valid[idx][victim] && dirty[idx][victim]) ? WRITEBACK : ALLOCATE;
                    end
                WRITEBACK:
                    if (pmem_resp) begin
                        dirty[idx][victim_q] <= 1'b0;
                        state                <= ALLOCATE;
                    end
                ALLOCATE:
                    if (pmem_resp) begin
                        valid[idx][victim_q] <= 1'b1;
                        dirty[idx][victim_q] <= 1'b0;
                        state                <= CHECK;
                    end
                default: state <= CHECK;
            endcase

`ifdef CACHE_STATS_EN
    logic [15:0] hits, misses;
    logic        filled;

    // saturating counters; the hit that completes a fill is not a real hit
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            hits   <= 16'h0;
            misses <= 16'h0;
            filled <= 1'b0;
        end else begin
            if (mem_resp) begin
                if (!filled && hits != 16'hFFFF) hits <= hits + 16'd1;
                filled <= 1'b0;
            end
            if (state == CHECK && req && !hit && misses != 16'hFFFF) misses <= misses + 16'd1;
            if (pmem_read && pmem_resp) filled <= 1'b1;
        end

    assign hit_count  = hits;
    assign miss_count = misses;
`else
    assign hit_count  = 16'h0;
    assign miss_count = 16'h0;
`endif
endmodule

// File: tb/tb_cache_nway_wb.sv
// tb_cache_nway_wb: randomized bench for cache_nway_wb against an LRU-queue and golden-memory reference model.
module tb_cache_nway_wb;
    localparam int WAYS = 2;
    localparam int SETS = 8;
`ifdef CACHE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_n;
    logic [15:0]  mem_address;
    logic         mem_read, mem_write;
    logic [1:0]   mem_byte_enable;
    logic [15:0]  mem_wdata, mem_rdata;
    logic         mem_resp;
    logic [15:0]  pmem_address;
    logic         pmem_read, pmem_write;
    logic [127:0] pmem_wdata, pmem_rdata;
    logic         pmem_resp;
    logic [15:0]  hit_count, miss_count;

    typedef struct {
        bit           wr;
        logic [15:0]  addr;
        logic [127:0] data;
    } ev_t;

    ev_t          evq[$];
    logic [127:0] bmem [4096];
    logic [127:0] gold [4096];
    bit           mdirty [4096];
    int           lru [SETS][$];
    int           m_hits, m_misses, n_checks, n_err;
    bit           overlap;
    logic [127:0] last_wb;
    logic [15:0]  last_wb_addr, rdata_q;

    cache_nway_wb #(.WAYS(WAYS), .SETS(SETS)) dut (
        .clk(clk), .reset_n(reset_n),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    // physical memory: random latency, one-cycle resp, logs every completed transaction
    initial begin
        int  lat;
        ev_t e;
        lat = -1;
        pmem_resp = 1'b0;
        pmem_rdata = '0;
        overlap = 1'b0;
        last_wb = '0;
        last_wb_addr = '0;
        forever begin
            @(negedge clk);
            pmem_resp = 1'b0;
            if (pmem_read && pmem_write) overlap = 1'b1;
            if (!reset_n || !(pmem_read || pmem_write)) lat = -1;
            else if (lat < 0) lat = int'($urandom_range(0, 3));
            else if (lat > 0) lat--;
            else begin
                e.wr = pmem_write;
                e.addr = pmem_address;
                e.data = pmem_wdata;
                if (pmem_write) begin
                    bmem[pmem_address[15:4]] = pmem_wdata;
                    last_wb = pmem_wdata;
                    last_wb_addr = pmem_address;
                end else
                    pmem_rdata = bmem[pmem_address[15:4]];
                evq.push_back(e);
                pmem_resp = 1'b1;
                lat = -1;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", tag, got, exp);
        end
    endtask

    task automatic reset_model();
        for (int s = 0; s < SETS; s++) lru[s].delete();
        for (int i = 0; i < 4096; i++) begin
            mdirty[i] = 1'b0;
            gold[i] = bmem[i];
        end
        m_hits = 0;
        m_misses = 0;
        evq.delete();
    endtask

    // one CPU request; model predicts hit/miss, eviction and data, then checks the DUT
    task automatic access(input logic [15:0] a, input bit rd, input bit wr, input logic [1:0] be, input logic [15:0] wd);
        int s, t, la, w, pos, cyc, vla, n_exp;
        bit hit, evd;
        logic [15:0] got;
        s = int'(a[6:4]);
        t = int'(a[15:7]);
        la = int'(a[15:4]);
        w = int'(a[3:1]);
        pos = -1;
        foreach (lru[s][i]) if (lru[s][i] == t) pos = i;
        hit = pos >= 0;
        evd = 1'b0;
        vla = 0;
        if (hit) lru[s].delete(pos);
        else if (lru[s].size() == WAYS) begin
            vla = lru[s].pop_front() * SETS + s;
            evd = mdirty[vla];
            mdirty[vla] = 1'b0;
        end
        lru[s].push_back(t);
        if (hit) m_hits++;
        else m_misses++;
        mem_address = a;
        mem_read = rd;
        mem_write = wr;
        mem_byte_enable = be;
        mem_wdata = wd;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!mem_resp && cyc < 100);
        got = mem_rdata;
        check("resp_seen", 128'(mem_resp), 128'(1));
        if (hit) check("hit_latency", 128'(cyc), 128'(1));
        else check("miss_latency_ge3", 128'(cyc >= 3), 128'(1));
        n_exp = hit ? 0 : (evd ? 2 : 1);
        check("pmem_txn_count", 128'(evq.size()), 128'(n_exp));
        if (!hit && evq.size() == n_exp) begin
            if (evd) begin
                check("wb_is_write", 128'(evq[0].wr), 128'(1));
                check("wb_addr", 128'(evq[0].addr), 128'(16'(vla << 4)));
                check("wb_data", evq[0].data, gold[vla]);
            end
            check("fill_is_read", 128'(evq[n_exp-1].wr), 128'(0));
            check("fill_addr", 128'(evq[n_exp-1].addr), 128'(16'(la << 4)));
        end
        if (rd && !wr) check("rdata", 128'(got), 128'(gold[la][w*16 +: 16]));
        if (wr) begin
            if (be[0]) gold[la][w*16 +: 8] = wd[7:0];
            if (be[1]) gold[la][w*16+8 +: 8] = wd[15:8];
            if (be != 2'b00) mdirty[la] = 1'b1;
        end
        evq.delete();
        rdata_q = got;
        @(posedge clk);
        #1;
        mem_read = 1'b0;
        mem_write = 1'b0;
    endtask

    initial begin
        int op, n;
        n_checks = 0;
        n_err = 0;
        reset_n = 1'b1;
        mem_address = '0;
        mem_read = 1'b0;
        mem_write = 1'b0;
        mem_byte_enable = '0;
        mem_wdata = '0;
        for (int i = 0; i < 4096; i++) bmem[i] = {$urandom, $urandom, $urandom, $urandom};
        bmem[12'h123][47:32] = 16'hBEEF;
        reset_model();
        #1 reset_n = 1'b0;
        #1;
        check("rst_mem_resp", 128'(mem_resp), 128'(0));
        check("rst_pmem_read", 128'(pmem_read), 128'(0));
        check("rst_pmem_write", 128'(pmem_write), 128'(0));
        check("rst_hit_count", 128'(hit_count), 128'(0));
        check("rst_miss_count", 128'(miss_count), 128'(0));
        #10 reset_n = 1'b1;
        @(posedge clk);
        #1;

        access(16'h1234, 1'b1, 1'b0, 2'b00, 16'h0);
        check("cold_read", 128'(rdata_q), 128'(16'hBEEF));
        access(16'h1234, 1'b1, 1'b0, 2'b00, 16'h0);
        check("warm_read", 128'(rdata_q), 128'(16'hBEEF));
        access(16'h1234, 1'b0, 1'b1, 2'b01, 16'h00AA);
        access(16'h1234, 1'b1, 1'b0, 2'b00, 16'h0);
        check("merged_read", 128'(rdata_q), 128'(16'hBEAA));
        access(16'h2230, 1'b1, 1'b0, 2'b00, 16'h0);
        access(16'h1230, 1'b1, 1'b0, 2'b00, 16'h0);
        access(16'h3230, 1'b1, 1'b0, 2'b00, 16'h0);
        access(16'h2230, 1'b1, 1'b0, 2'b00, 16'h0);
        check("wb_line_addr", 128'(last_wb_addr), 128'(16'h1230));
        check("wb_line_word2", 128'(last_wb[47:32]), 128'(16'hBEAA));

        repeat (300) begin
            op = int'($urandom_range(0, 3));
            access(16'(($urandom_range(1, 5) << 7) | ($urandom_range(0, 7) << 4) | ($urandom_range(0, 7) << 1)),
                   op != 2, op >= 2, 2'($urandom_range(0, 3)), 16'($urandom));
        end
        check("rand_hit_count", 128'(hit_count), 128'(STATS ? 16'(m_hits) : 16'h0));
        check("rand_miss_count", 128'(miss_count), 128'(STATS ? 16'(m_misses) : 16'h0));

        mem_address = 16'h5670;
        mem_read = 1'b1;
        n = 0;
        while (!pmem_read && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("alloc_reached", 128'(pmem_read), 128'(1));
        reset_n = 1'b0;
        #1;
        check("midmiss_pmem_read", 128'(pmem_read), 128'(0));
        check("midmiss_pmem_write", 128'(pmem_write), 128'(0));
        check("midmiss_mem_resp", 128'(mem_resp), 128'(0));
        check("midmiss_hit_count", 128'(hit_count), 128'(0));
        check("midmiss_miss_count", 128'(miss_count), 128'(0));
        mem_read = 1'b0;
        @(negedge clk);
        #1 reset_n = 1'b1;
        reset_model();
        @(posedge clk);
        #1;

        access(16'h1234, 1'b1, 1'b0, 2'b00, 16'h0);
        access(16'h1234, 1'b1, 1'b0, 2'b00, 16'h0);
        access(16'h1234, 1'b1, 1'b0, 2'b00, 16'h0);
        access(16'h2234, 1'b1, 1'b0, 2'b00, 16'h0);
        access(16'h2234, 1'b1, 1'b0, 2'b00, 16'h0);
        access(16'h3234, 1'b1, 1'b0, 2'b00, 16'h0);
        access(16'h3234, 1'b1, 1'b0, 2'b00, 16'h0);
        access(16'h2234, 1'b1, 1'b0, 2'b00, 16'h0);
        check("stats_hit_count", 128'(hit_count), 128'(STATS ? 16'd5 : 16'h0));
        check("stats_miss_count", 128'(miss_count), 128'(STATS ? 16'd3 : 16'h0));
        check("pmem_never_overlap", 128'(overlap), 128'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
